// File: rtl/small_fifo_stream_reader.sv
// Read-side adapter for small_fifo. It turns the FIFO's rd_en/empty/registered-dout port
// into a first-word-fall-through valid/ready stream, using a 3-entry holding buffer.
module small_fifo_stream_reader #(
  parameter int WIDTH     = 72,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] words_out,
  output logic                 rd_err
);

  logic [2:0][WIDTH-1:0] entry;
  logic [1:0]            occ;
  logic [1:0]            head;
  logic [1:0]            tail;
  logic                  inflight;
  logic [2:0]            pending;
  logic                  capture;
  logic                  pop;
  logic [1:0]            occ_next;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is issued only when a slot is already reserved for it, so out_ready
  // never reaches fifo_rd_en.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = ~reset & ~flush & ~fifo_empty & (pending < 3'd3);

  assign capture   = inflight & ~flush;
  assign out_valid = (occ != 2'd0) & ~flush;
  assign out_data  = entry[head];
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_next = occ;
    case ({capture, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry     <= '0;
      occ       <= 2'd0;
      head      <= 2'd0;
      tail      <= 2'd0;
      inflight  <= 1'b0;
      words_out <= '0;
      rd_err    <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      rd_err   <= rd_err | (fifo_rd_en & fifo_empty);
      if (flush) begin
        // Entries keep their stale contents. They are unreachable once occ is 0.
        occ  <= 2'd0;
        head <= 2'd0;
        tail <= 2'd0;
      end else begin
        occ <= occ_next;
        if (capture) begin
          entry[tail] <= fifo_dout;
          tail        <= inc3(tail);
        end
        if (pop) begin
          head      <= inc3(head);
          words_out <= words_out + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_small_fifo_stream_reader.sv
// Directed and randomized bench for small_fifo_stream_reader. It includes a behavioural
// small_fifo model (registered dout) and an in-order scoreboard.
module tb_small_fifo_stream_reader;
  localparam int W  = 72;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] words_out;
  logic          rd_err;

  always #5 clk = ~clk;

  small_fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .words_out(words_out), .rd_err(rd_err)
  );

  // Behavioural FIFO: dout is registered one cycle after rd_en.
  logic [W-1:0] fq[$];
  int           fcount = 0;
  assign fifo_empty = (fcount == 0);
  always @(posedge clk) begin
    if (fifo_rd_en && fcount > 0) begin
      fifo_dout <= fq.pop_front();
      fcount    <= fcount - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor. It samples just after the negedge, when inputs for the next posedge are settled.
  logic [W-1:0] sb[$];
  logic         sb_en = 1'b0;
  int           received = 0;
  int           viol = 0;
  always @(negedge clk) begin
    #1;
    if (sb_en) begin
      if (fifo_rd_en && fifo_empty) viol++;
      if (out_valid && out_ready) begin
        received++;
        if (sb.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
        else chk("sb_order", out_data, sb.pop_front());
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    fcount = fcount + 1;
  endtask

  // Leaves the caller on a negedge, with reset still high and the FIFO holding n words base..base+n-1.
  task automatic reset_and_load(input int n, input int base);
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fq.delete(); fcount = 0;
    for (int k = 0; k < n; k++) push_word(W'(base + k));
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic         rd;
    logic         vld;
    logic [W-1:0] data;
  } vec_t;
  vec_t tv[11];

  initial begin
    int rd_cnt;
    int got;
    logic found;
    logic [W-1:0] w;

    // Cycle-by-cycle expectations for the streaming test, indexed from reset release.
    tv[0]  = '{1'b1, 1'b0, '0};
    tv[1]  = '{1'b1, 1'b0, '0};
    for (int i = 2; i <= 7; i++) tv[i] = '{1'b1, 1'b1, W'(i - 1)};
    tv[8]  = '{1'b0, 1'b1, W'(7)};
    tv[9]  = '{1'b0, 1'b1, W'(8)};
    tv[10] = '{1'b0, 1'b0, '0};

    // Reset is held with the FIFO non-empty.
    for (int k = 1; k <= 8; k++) push_word(W'(k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, '0);
      chk("rst_words", words_out, '0);
    end

    // Streaming with out_ready held high.
    reset_and_load(8, 1);
    out_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("stream_rd[%0d]", i), fifo_rd_en, tv[i].rd);
      chk($sformatf("stream_vld[%0d]", i), out_valid, tv[i].vld);
      if (tv[i].vld) chk($sformatf("stream_data[%0d]", i), out_data, tv[i].data);
    end
    chk("stream_words", words_out, W'(8));
    chk("stream_rd_err", rd_err, 1'b0);

    // Backpressure: only three reads may be issued while the output is stalled.
    reset_and_load(8, 1);
    reset = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (fifo_rd_en) rd_cnt++;
    end
    chk("bp_rd_count", W'(rd_cnt), W'(3));
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_hold_data", out_data, W'(1));
    out_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_vld[%0d]", k), out_valid, 1'b1);
      chk($sformatf("bp_data[%0d]", k), out_data, W'(k));
    end
    @(negedge clk); #1;
    chk("bp_words", words_out, W'(8));

    // Flush while occ is 2 and a third word is in flight.
    reset_and_load(8, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("fl_pre_valid", out_valid, 1'b1);
    chk("fl_pre_rd", fifo_rd_en, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_rd", fifo_rd_en, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_next_valid", out_valid, 1'b0);
    chk("fl_words", words_out, '0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      found = out_valid;
    end
    chk("fl_found", found, 1'b1);
    chk("fl_next_word", out_data, W'(4));

    // Reset asserted partway through the stream.
    reset_and_load(8, 1);
    out_ready = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 20 && words_out != 4; c++) begin
      @(negedge clk); #1;
    end
    chk("mr_pre_words", words_out, W'(4));
    reset = 1'b1;
    fq.delete(); fcount = 0;
    for (int k = 0; k < 4; k++) push_word(W'(8'hA1 + k));
    @(negedge clk); #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_rd", fifo_rd_en, 1'b0);
    chk("mr_words", words_out, '0);
    @(negedge clk);
    reset = 1'b0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (out_valid && out_ready) begin
        if (got < 4) chk($sformatf("mr_data[%0d]", got), out_data, W'(8'hA1 + got));
        else chk("mr_stale", out_data, '1);
        got++;
      end
      @(negedge clk);
    end
    chk("mr_count", W'(got), W'(4));
    chk("mr_words_end", words_out, W'(4));

    // Random stalls against the scoreboard.
    reset_and_load(0, 0);
    reset = 1'b0;
    sb.delete(); received = 0; viol = 0;
    sb_en = 1'b1;
    got = 0;
    for (int c = 0; c < 8000 && received < 1000; c++) begin
      out_ready = ($urandom_range(0, 9) >= 3);
      if (got < 1000 && $urandom_range(0, 9) < 8) begin
        w = {8'($urandom), $urandom, $urandom};
        push_word(w);
        sb.push_back(w);
        got++;
      end
      @(negedge clk);
    end
    #2;
    sb_en = 1'b0;
    chk("rnd_received", W'(received), W'(1000));
    chk("rnd_words", words_out, W'(1000));
    chk("rnd_sb_empty", W'(sb.size()), '0);
    chk("rnd_viol", W'(viol), '0);
    chk("rnd_rd_err", rd_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
